// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by a programmer, a core data port and a core fetch port.
// Fixed priority: programmer, then data, then instruction; the core is stalled via mem_hold.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog_ena,
  input  logic              prog_we,
  input  logic [31:0]       prog_addr,
  input  logic [31:0]       prog_din,
  input  logic              imem_en,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_dout,
  input  logic              mem_wea,
  input  logic              mem_rea,
  input  logic [3:0]        mem_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_din,
  output logic [31:0]       mem_dout,
  output logic              mem_hold,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam int unsigned BE_W  = 4;
  localparam int unsigned AW_HI = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_RD  = 3'd1,
    I_ISS = 3'd2,
    I_RD  = 3'd3,
    DONE  = 3'd4,
    PROG  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Byte-offset and out-of-range address bits are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{prog_addr[31:AW_HI+1], prog_addr[1:0],
                              imem_addr[31:AW_HI+1], imem_addr[1:0],
                              mem_addr[31:AW_HI+1],  mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and RAM port steering; everything forced idle while in reset.
  always_comb begin
    state_nxt = state;
    mem_hold  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_din   = '0;
    if (!Rst) begin
      case (state)
        IDLE: begin
          if (prog_ena) begin
            mem_hold  = 1'b1;
            state_nxt = PROG;
          end else if (mem_wea) begin
            ram_en   = 1'b1;
            ram_we   = mem_en;
            ram_addr = mem_addr[AW_HI:2];
            ram_din  = mem_din;
            if (imem_en) begin
              mem_hold  = 1'b1;
              state_nxt = I_ISS;
            end
          end else if (mem_rea) begin
            ram_en    = 1'b1;
            ram_addr  = mem_addr[AW_HI:2];
            mem_hold  = 1'b1;
            state_nxt = D_RD;
          end else if (imem_en) begin
            ram_en    = 1'b1;
            ram_addr  = imem_addr[AW_HI:2];
            mem_hold  = 1'b1;
            state_nxt = I_RD;
          end
        end
        D_RD: begin
          mem_hold = 1'b1;
          if (imem_en) begin
            ram_en    = 1'b1;
            ram_addr  = imem_addr[AW_HI:2];
            state_nxt = I_RD;
          end else begin
            state_nxt = DONE;
          end
        end
        I_ISS: begin
          mem_hold  = 1'b1;
          ram_en    = 1'b1;
          ram_addr  = imem_addr[AW_HI:2];
          state_nxt = I_RD;
        end
        I_RD: begin
          mem_hold  = 1'b1;
          state_nxt = DONE;
        end
        DONE: begin
          state_nxt = IDLE;
        end
        PROG: begin
          mem_hold = 1'b1;
          ram_en   = prog_we;
          ram_we   = {BE_W{prog_we}};
          ram_addr = prog_addr[AW_HI:2];
          ram_din  = prog_din;
          if (!prog_ena) state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Read data is captured only in the cycle after its issue; otherwise held.
  always_ff @(posedge clk) begin
    if (Rst) begin
      mem_dout  <= '0;
      imem_dout <= '0;
    end else begin
      if (state == D_RD) mem_dout  <= ram_dout;
      if (state == I_RD) imem_dout <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural RAM and word-level reference model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned N_RAND = 300;

  logic              clk = 1'b0;
  logic              Rst;
  logic              prog_ena, prog_we;
  logic [31:0]       prog_addr, prog_din;
  logic              imem_en;
  logic [31:0]       imem_addr, imem_dout;
  logic              mem_wea, mem_rea;
  logic [3:0]        mem_en;
  logic [31:0]       mem_addr, mem_din, mem_dout;
  logic              mem_hold, ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din, ram_dout;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .Rst(Rst),
    .prog_ena(prog_ena), .prog_we(prog_we), .prog_addr(prog_addr), .prog_din(prog_din),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .mem_wea(mem_wea), .mem_rea(mem_rea), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_hold(mem_hold),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] md;
    logic [31:0] id;
    int          stalls;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } slot_t;

  exp_t        exp_q[$];
  slot_t       prog_q[$];
  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        ram_init;
  logic        busy = 1'b0;
  logic [31:0] cur_md, cur_id;
  int          n_checks = 0;
  int          n_errors = 0;
  int          stall_cnt = 0;

  function automatic logic [31:0] seed_word(input int unsigned i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  function automatic logic [31:0] mk_addr(input int unsigned w);
    logic [31:0] a;
    a = $urandom;
    a[ADDR_W+1:2] = ADDR_W'(w);
    return a;
  endfunction

  // Behavioural single-port RAM: byte-lane writes, read data one cycle after issue.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram[i] <= seed_word(i);
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= ram[ram_addr];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // Monitor: counts stall cycles and scores a transaction when mem_hold drops.
  always @(negedge clk) begin
    if (busy) begin
      if (mem_hold === 1'b1) begin
        stall_cnt++;
      end else begin
        exp_t e;
        check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          check("mem_dout", mem_dout, e.md);
          check("imem_dout", imem_dout, e.id);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    prog_ena = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_din = '0;
    imem_en = 1'b0; imem_addr = '0;
    mem_wea = 1'b0; mem_rea = 1'b0; mem_en = '0; mem_addr = '0; mem_din = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (mem_hold !== 1'b0) begin
      n++;
      if (n > 40) begin
        check("hold_timeout", 32'(mem_hold), 32'd0);
        finish_sim();
      end
      @(negedge clk);
    end
    tick();
    clear_in();
    busy = 1'b0;
  endtask

  task automatic push_exp(input int stalls);
    exp_t e;
    e.md = cur_md;
    e.id = cur_id;
    e.stalls = stalls;
    exp_q.push_back(e);
  endtask

  task automatic do_write(input logic [3:0] en, input logic [31:0] a, input logic [31:0] d,
                          input logic fetch, input logic [31:0] ia);
    int unsigned w = widx(a);
    for (int b = 0; b < 4; b++)
      if (en[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    if (fetch) cur_id = ref_mem[widx(ia)];
    push_exp(fetch ? 3 : 0);
    mem_wea = 1'b1; mem_rea = 1'($urandom_range(0, 1));
    mem_en = en; mem_addr = a; mem_din = d; imem_en = fetch; imem_addr = ia;
    busy = 1'b1;
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] a, input logic fetch, input logic [31:0] ia);
    cur_md = ref_mem[widx(a)];
    if (fetch) cur_id = ref_mem[widx(ia)];
    push_exp(fetch ? 3 : 2);
    mem_rea = 1'b1; mem_en = 4'($urandom); mem_addr = a; mem_din = $urandom;
    imem_en = fetch; imem_addr = ia;
    busy = 1'b1;
    wait_done();
  endtask

  task automatic do_fetch(input logic [31:0] ia);
    cur_id = ref_mem[widx(ia)];
    push_exp(2);
    imem_en = 1'b1; imem_addr = ia; mem_addr = $urandom; mem_din = $urandom;
    busy = 1'b1;
    wait_done();
  endtask

  task automatic add_slot(input logic we, input logic [31:0] a, input logic [31:0] d);
    slot_t s;
    s.we = we; s.addr = a; s.data = d;
    prog_q.push_back(s);
  endtask

  task automatic do_prog(input logic ie, input logic [31:0] ia);
    for (int k = 0; k < prog_q.size(); k++)
      if (prog_q[k].we) ref_mem[widx(prog_q[k].addr)] = prog_q[k].data;
    push_exp(prog_q.size() + 2);
    prog_ena = 1'b1; imem_en = ie; imem_addr = ia;
    mem_rea = 1'($urandom_range(0, 1)); mem_addr = $urandom;
    busy = 1'b1;
    @(negedge clk);
    check("prog_entry_ram_en", 32'(ram_en), 32'd0);
    tick();
    for (int k = 0; k < prog_q.size(); k++) begin
      prog_we = prog_q[k].we; prog_addr = prog_q[k].addr; prog_din = prog_q[k].data;
      @(negedge clk);
      check("prog_ram_we", 32'(ram_we), prog_q[k].we ? 32'hF : 32'h0);
      check("prog_ram_en", 32'(ram_en), 32'(prog_q[k].we));
      if (prog_q[k].we) check("prog_ram_addr", 32'(ram_addr), 32'(widx(prog_q[k].addr)));
      tick();
    end
    prog_ena = 1'b0; prog_we = 1'b0;
    prog_q.delete();
    wait_done();
  endtask

  initial begin
    #2_000_000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got time limit reached, expected completion");
    finish_sim();
  end

  initial begin
    int kind, nslot;
    clear_in();
    Rst = 1'b1; ram_init = 1'b1;
    cur_md = '0; cur_id = '0;
    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);

    @(negedge clk);
    check("rst_mem_hold", 32'(mem_hold), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    tick();
    ram_init = 1'b0;
    @(negedge clk);
    check("rst_mem_dout", mem_dout, 32'd0);
    check("rst_imem_dout", imem_dout, 32'd0);
    tick();
    Rst = 1'b0;

    // Lone partial write: issued in the request cycle with no stall.
    mem_wea = 1'b1; mem_en = 4'b0011; mem_addr = 32'h10; mem_din = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_ram_we", 32'(ram_we), 32'h3);
    check("wr_ram_addr", 32'(ram_addr), 32'h4);
    check("wr_ram_en", 32'(ram_en), 32'd1);
    check("wr_ram_din", ram_din, 32'hDEADBEEF);
    check("wr_mem_hold", 32'(mem_hold), 32'd0);
    ref_mem[4][15:0] = 16'hBEEF;
    tick();
    clear_in();

    // Data read plus fetch in one request.
    do_write(4'hF, 32'h10, 32'h12345678, 1'b0, 32'h0);
    do_write(4'hF, 32'h0, 32'h00000013, 1'b0, 32'h0);
    do_read(32'h10, 1'b1, 32'h0);
    check("rdf_mem_dout", mem_dout, 32'h12345678);
    check("rdf_imem_dout", imem_dout, 32'h00000013);

    // Write plus fetch of the same word returns the new data.
    do_write(4'hF, 32'h20, 32'hCAFE0001, 1'b1, 32'h20);
    check("wrf_imem_dout", imem_dout, 32'hCAFE0001);

    // Programmer burst with fetch requested throughout.
    add_slot(1'b1, 32'h0, 32'hA);
    add_slot(1'b0, 32'h0, 32'h0);
    add_slot(1'b1, 32'h4, 32'hB);
    add_slot(1'b0, 32'h4, 32'h0);
    do_prog(1'b1, 32'h0);
    do_fetch(32'h0);
    check("prog_fetch", imem_dout, 32'hA);

    // Reset while a data read is in flight.
    mem_rea = 1'b1; mem_addr = 32'h10;
    tick();
    Rst = 1'b1;
    @(negedge clk);
    check("rst_drd_ram_en", 32'(ram_en), 32'd0);
    check("rst_drd_hold", 32'(mem_hold), 32'd0);
    tick();
    Rst = 1'b0;
    clear_in();
    cur_md = '0; cur_id = '0;
    @(negedge clk);
    check("post_rst_mem_dout", mem_dout, 32'd0);
    check("post_rst_hold", 32'(mem_hold), 32'd0);
    check("post_rst_ram_en", 32'(ram_en), 32'd0);
    tick();

    // Reset during a programmer write must not reach the RAM.
    prog_ena = 1'b1;
    tick();
    prog_we = 1'b1; prog_addr = 32'h1C; prog_din = 32'hBAD0BAD0; Rst = 1'b1;
    @(negedge clk);
    check("rst_prog_ram_we", 32'(ram_we), 32'd0);
    check("rst_prog_ram_en", 32'(ram_en), 32'd0);
    tick();
    Rst = 1'b0;
    clear_in();
    do_read(32'h1C, 1'b0, 32'h0);

    for (int unsigned it = 0; it < N_RAND; it++) begin
      repeat ($urandom_range(0, 2)) tick();
      kind = int'($urandom_range(0, 19));
      if (kind < 7) begin
        do_write(4'($urandom), mk_addr($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 15)));
      end else if (kind < 13) begin
        do_read(mk_addr($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                mk_addr($urandom_range(0, 15)));
      end else if (kind < 18) begin
        do_fetch(mk_addr($urandom_range(0, 15)));
      end else begin
        nslot = int'($urandom_range(1, 4));
        for (int k = 0; k < nslot; k++)
          add_slot(1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 15)), $urandom);
        do_prog(1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 15)));
      end
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    finish_sim();
  end

endmodule
